// File: rtl/legv8_pkg.sv
// legv8_pkg: shared fetch widths, reset PC and fetch FSM state encoding.
package legv8_pkg;
  localparam int PC_W_DEF = 32;
  localparam int INSTR_W_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  typedef enum logic {BOOT = 1'b0, FETCH = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: one-entry valid/ready holding register between fetch and decode.
module fetch_out_buf #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic          flush,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] pc_in,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW-1:0] pc
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      pc    <= pc_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: LEGv8 program counter and instruction fetch controller.
// Optional macro PC_ADDER_CHECK_EN adds a sticky check of the external PC adder.
module pc_fetch_ctrl
  import legv8_pkg::*;
#(
  parameter int PC_WIDTH = PC_W_DEF,
  parameter int INSTR_WIDTH = INSTR_W_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_WIDTH-1:0]    pc_out,
  input  logic [PC_WIDTH-1:0]    pc_plus1_in,
  output logic                   imem_req,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   br_taken,
  input  logic [PC_WIDTH-1:0]    br_target,
  input  logic                   stall,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   adder_err
);
  fetch_state_t state, state_d;
  logic done;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else state <= state_d;
  end
  always_comb begin
    state_d  = FETCH;
    imem_req = (state == FETCH) && !stall && !br_taken && (!instr_valid || instr_ready);
    done     = imem_req && imem_ready;
  end
  // Branch wins over a completing fetch; the returned word is dropped by the flush.
  always_ff @(posedge clk) begin
    if (!rst_n) pc_out <= RESET_PC;
    else if (br_taken) pc_out <= br_target;
    else if (done) pc_out <= pc_plus1_in;
  end
  fetch_out_buf #(.DW(INSTR_WIDTH), .AW(PC_WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (done),
    .drain   (instr_ready),
    .flush   (br_taken),
    .data_in (imem_rdata),
    .pc_in   (pc_out),
    .valid   (instr_valid),
    .data    (instr_out),
    .pc      (instr_pc)
  );
`ifdef PC_ADDER_CHECK_EN
  logic err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (done && (pc_plus1_in != pc_out + PC_WIDTH'(1))) begin
      err <= 1'b1;
`ifndef SYNTHESIS
      $display("pc_fetch_ctrl: adder error at pc %h: got %h, expected %h", pc_out, pc_plus1_in, pc_out + PC_WIDTH'(1));
`endif
    end
  end
  assign adder_err = err;
`else
  assign adder_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: randomized and directed checks of pc_fetch_ctrl against a cycle reference model.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_out, pc_plus1_in, imem_rdata, br_target = '0, instr_out, instr_pc;
  logic        imem_req, imem_ready = 1'b0, br_taken = 1'b0, stall = 1'b0;
  logic        instr_valid, instr_ready = 1'b0, adder_err;
  logic        inj = 1'b0;
  int          n_chk = 0, n_fail = 0;
  logic        armed = 1'b0;
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_boot, m_valid, m_err;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[29:0], 2'b00} ^ 32'h5A00_0000;
  endfunction

  assign pc_plus1_in = pc_out + (inj ? 32'd2 : 32'd1);
  assign imem_rdata  = mem(pc_out);

  pc_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_out      (pc_out),
    .pc_plus1_in (pc_plus1_in),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .adder_err   (adder_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic b, input logic [31:0] t, input logic s,
                     input logic mr, input logic dr);
    logic req;
    @(negedge clk);
    rst_n = r; br_taken = b; br_target = t; stall = s; imem_ready = mr; instr_ready = dr;
    #1;
    req = !m_boot && !s && !b && (!m_valid || dr);
    if (armed) begin
      check("imem_req", {31'd0, imem_req}, {31'd0, req});
      check("pc_out", pc_out, m_pc);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      check("instr_pc", instr_pc, m_ipc);
      check("instr_out", instr_out, m_instr);
      check("adder_err", {31'd0, adder_err}, {31'd0, m_err});
    end
    if (!r) begin
      m_pc = 32'h0; m_boot = 1'b1; m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_err = 1'b0;
    end else begin
      if (b) begin
        m_pc = t; m_valid = 1'b0;
      end else if (req && mr) begin
        m_instr = mem(m_pc); m_ipc = m_pc; m_valid = 1'b1;
`ifdef PC_ADDER_CHECK_EN
        if (inj) m_err = 1'b1;
`endif
        m_pc = m_pc + (inj ? 32'd2 : 32'd1);
      end else if (m_valid && dr) begin
        m_valid = 1'b0;
      end
      m_boot = 1'b0;
    end
    armed = 1'b1;
  endtask

  initial begin
    int k;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    // Continuous fetch from reset: first valid at the second edge, then one per cycle.
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    check("first_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1, 0, 0, 0, 1, 1);
    check("first_pc", instr_pc, 32'd0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 1);
    // Decode back-pressure after the first instruction.
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0);
    check("hold_ipc", instr_pc, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1);
    // Branch coinciding with a returned word at pc 7.
    k = 0;
    while (m_pc != 32'd7 && k < 20) begin cyc(1, 0, 0, 0, 1, 1); k++; end
    check("reach_pc7", m_pc, 32'd7);
    cyc(1, 1, 32'h100, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1);
    // Branch during a stall window.
    cyc(1, 0, 0, 1, 1, 1);
    cyc(1, 1, 32'h40, 1, 1, 1);
    cyc(1, 0, 0, 1, 1, 1);
    check("stall_br_pc", pc_out, 32'h40);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1);
    // PC wrap through the adder.
    cyc(1, 1, 32'hFFFF_FFFE, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 1);
    check("wrap_pc", pc_out, 32'h1);
`ifdef PC_ADDER_CHECK_EN
    cyc(1, 1, 32'h5, 0, 1, 1);
    inj = 1'b1;
    cyc(1, 0, 0, 0, 1, 1);
    inj = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 1);
    check("err_sticky", {31'd0, adder_err}, 32'd1);
    cyc(0, 0, 0, 0, 1, 1);
`endif
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0, $urandom,
          $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    cyc(1, 0, 0, 0, 1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
